door_timer_fsm: RTL and testbench
=================================

Name: door_timer_fsm

Overview:
- Elevator car door sequencer; directly downstream of the tick divider.
- Drives the divider's enable input through `tick_en`.
- Consumes the divider's one-cycle `div_edge` pulse as `tick`.
- Times the door through four phases: opening, hold-open, closing, closed.
- Reopens on obstruction or the open button, and reports door status to the floor controller.

Parameters:
- OPEN_TICKS, 3, ticks spent in OPENING (must be >= 1)
- HOLD_TICKS, 5, ticks door stays fully open before auto-close (must be >= 1)
- CLOSE_TICKS, 3, ticks spent in CLOSING (must be >= 1)

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-low reset
- tick  input  1  one-cycle time-base pulse from the divider
- open_req  input  1  level/pulse from floor controller: car arrived, open door
- open_btn  input  1  cabin open button (synchronised, level)
- close_btn  input  1  cabin close button (synchronised, level)
- obstruct  input  1  door-edge sensor (synchronised, level)
- tick_en  output  1  enable to tick divider; high in every state except CLOSED
- door_state  output  2  0=CLOSED, 1=OPENING, 2=OPEN, 3=CLOSING
- door_closed  output  1  high iff state is CLOSED
- closed_pulse  output  1  one-cycle pulse on the cycle the state becomes CLOSED

Behaviour:
- Interface: one clock, `clk`; reset is synchronous and active-low, named `reset`. All logic updates on the rising edge of `clk`.
- Reset (`reset`=0 at a rising edge):
  - State=CLOSED, internal tick counter cnt=0.
  - Outputs: door_state=0, door_closed=1, tick_en=0, closed_pulse=0.
  - Reset mid-operation abandons any phase immediately; no pulse is emitted.
- Counter:
  - cnt width = $clog2(max(OPEN_TICKS,HOLD_TICKS,CLOSE_TICKS)+1).
  - Cleared to 0 on every state transition.
  - Increments only on tick; never wraps, because each phase exits at its terminal count.
- Outputs are decoded from the state register; closed_pulse is registered, high exactly the cycle after the transition into CLOSED.
- CLOSED:
  - tick is ignored.
  - open_req or open_btn -> OPENING next cycle.
  - tick_en rises in the same cycle door_state becomes 1. The divider restarts from 0 when enabled, so the first tick arrives one divider period later.
- OPENING:
  - On tick with cnt==OPEN_TICKS-1 -> OPEN; otherwise tick increments cnt.
  - open_req, open_btn, close_btn and obstruct are ignored.
- OPEN, highest priority first:
  - (1) open_btn, obstruct or open_req: cnt<=0, restarting the hold. This overrides a coincident tick and a coincident close_btn.
  - (2) close_btn -> CLOSING next cycle, without waiting for a tick.
  - (3) tick with cnt==HOLD_TICKS-1 -> CLOSING.
  - (4) tick: cnt++.
- CLOSING, highest priority first:
  - (1) obstruct, open_btn or open_req -> OPENING with cnt=0. This is a full reopen and overrides a coincident terminal tick.
  - (2) tick with cnt==CLOSE_TICKS-1 -> CLOSED.
  - (3) tick: cnt++.
  - close_btn is ignored.
- Entering CLOSED:
  - door_closed=1, tick_en=0 and closed_pulse=1, all in the same cycle.
  - Any tick arriving while tick_en is low is ignored.
- Latency: door_closed falls 1 cycle after open_req is sampled in CLOSED.
- Total open cycle, undisturbed: OPEN_TICKS+HOLD_TICKS+CLOSE_TICKS ticks.

Test Plan:
- Reset:
  - Stimulus: hold reset=0 for 3 cycles with open_req=1.
  - Required: door_state=0, door_closed=1, tick_en=0, closed_pulse=0 throughout; state still CLOSED on the first cycle after release only if open_req was deasserted.
- Undisturbed cycle:
  - Stimulus: defaults 3/5/3, tick every 4 cycles once tick_en is high; pulse open_req once.
  - Required: door_state steps 1->2 on the 3rd tick, 2->3 on the 8th tick, 3->0 on the 11th tick; closed_pulse is high exactly 1 cycle; tick_en is low afterwards.
- Hold restart:
  - Stimulus: in OPEN after 4 hold ticks, assert obstruct for 1 cycle coincident with a tick.
  - Required: cnt resets to 0; CLOSING is entered only after 5 further ticks.
- Early close:
  - Stimulus: in OPEN with cnt=1, assert close_btn for 1 cycle.
  - Required: door_state=3 the next cycle. Repeat with open_btn and close_btn both high: state stays 2 and the hold restarts.
- Reopen during closing:
  - Stimulus: in CLOSING, assert obstruct on the same cycle as the 3rd (terminal) tick.
  - Required: door_state=1 next cycle, no closed_pulse, and OPENING lasts the full 3 ticks.
- Ignored inputs:
  - Stimulus: drive tick every cycle while CLOSED; drive close_btn and obstruct while OPENING.
  - Required: no state change from the ticks while CLOSED; OPENING exits only on its 3rd tick.
- Reset mid-operation:
  - Stimulus: assert reset=0 in OPEN.
  - Required: CLOSED/tick_en=0 at the next edge, no closed_pulse.

Source files
------------

// File: rtl/door_timer_fsm_if.sv
// ---------------------------------------------------------------------------
// door_timer_fsm_if
// Groups the door sequencer's time-base, request and status signals.
//   master : floor controller / cabin side (drives requests and tick,
//            reads door status)
//   slave  : door_timer_fsm itself
// Signals:
//   tick         one-cycle time-base pulse from the tick divider
//   open_req     car arrived at floor, open the door
//   open_btn     cabin open button (synchronised level)
//   close_btn    cabin close button (synchronised level)
//   obstruct     door-edge sensor (synchronised level)
//   tick_en      enable back to the tick divider
//   door_state   0=CLOSED 1=OPENING 2=OPEN 3=CLOSING
//   door_closed  high while the door is closed
//   closed_pulse one-cycle pulse on arrival in CLOSED
// ---------------------------------------------------------------------------
interface door_timer_fsm_if;
    logic       tick;
    logic       open_req;
    logic       open_btn;
    logic       close_btn;
    logic       obstruct;
    logic       tick_en;
    logic [1:0] door_state;
    logic       door_closed;
    logic       closed_pulse;

    modport master (
        output tick, open_req, open_btn, close_btn, obstruct,
        input  tick_en, door_state, door_closed, closed_pulse
    );

    modport slave (
        input  tick, open_req, open_btn, close_btn, obstruct,
        output tick_en, door_state, door_closed, closed_pulse
    );
endinterface

// File: rtl/door_timer_fsm.sv
// ---------------------------------------------------------------------------
// door_timer_fsm
// Elevator car door sequencer. Times the door through opening, hold-open,
// closing and closed phases using ticks from the tick divider, reopens on
// obstruction or open requests, and reports status to the floor controller.
// Ports:
//   clk    system clock, all logic on its rising edge
//   reset  synchronous active-low reset
//   bus    door_timer_fsm_if.slave (tick/requests in, status/tick_en out)
//
// state    | meaning
// ---------+----------------------------------------------------------
// CLOSED   | door shut, divider disabled, ticks ignored
// OPENING  | door moving open for OPEN_TICKS ticks, requests ignored
// OPEN     | door held open for HOLD_TICKS ticks, restarts on request
// CLOSING  | door moving shut for CLOSE_TICKS ticks, reopens on request
// ---------------------------------------------------------------------------
module door_timer_fsm #(
    parameter int OPEN_TICKS  = 3,
    parameter int HOLD_TICKS  = 5,
    parameter int CLOSE_TICKS = 3
) (
    input  logic               clk,
    input  logic               reset,
    door_timer_fsm_if.slave    bus
);

    localparam int MAX_OH    = (OPEN_TICKS > HOLD_TICKS) ? OPEN_TICKS : HOLD_TICKS;
    localparam int MAX_TICKS = (MAX_OH > CLOSE_TICKS) ? MAX_OH : CLOSE_TICKS;
    localparam int CW        = $clog2(MAX_TICKS + 1);

    localparam logic [CW-1:0] OPEN_LAST  = CW'(OPEN_TICKS - 1);
    localparam logic [CW-1:0] HOLD_LAST  = CW'(HOLD_TICKS - 1);
    localparam logic [CW-1:0] CLOSE_LAST = CW'(CLOSE_TICKS - 1);

    typedef enum logic [1:0] {
        ST_CLOSED  = 2'd0,
        ST_OPENING = 2'd1,
        ST_OPEN    = 2'd2,
        ST_CLOSING = 2'd3
    } state_t;

    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic          r_closed_pulse;

    state_t        w_state_nxt;
    logic [CW-1:0] w_cnt_nxt;
    logic          w_enter_closed;
    logic          w_reopen;

    // Any of these holds the door open (OPEN) or forces a reopen (CLOSING).
    assign w_reopen       = bus.open_req | bus.open_btn | bus.obstruct;
    assign w_enter_closed = (r_state != ST_CLOSED) && (w_state_nxt == ST_CLOSED);

    // State register. Reset wins over everything, so an abandoned phase
    // never produces a closed_pulse.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state        <= ST_CLOSED;
            r_cnt          <= '0;
            r_closed_pulse <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_cnt          <= w_cnt_nxt;
            r_closed_pulse <= w_enter_closed;
        end
    end

    // Next-state and counter. The counter is cleared on every transition,
    // so each phase exits at its terminal count and never wraps.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            ST_CLOSED: begin
                w_cnt_nxt = '0;
                if (bus.open_req || bus.open_btn) begin
                    w_state_nxt = ST_OPENING;
                end
            end
            ST_OPENING: begin
                if (bus.tick) begin
                    if (r_cnt == OPEN_LAST) begin
                        w_state_nxt = ST_OPEN;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt = r_cnt + CW'(1);
                    end
                end
            end
            ST_OPEN: begin
                if (w_reopen) begin
                    // Restart the hold; beats close_btn and a terminal tick.
                    w_cnt_nxt = '0;
                end else if (bus.close_btn) begin
                    w_state_nxt = ST_CLOSING;
                    w_cnt_nxt   = '0;
                end else if (bus.tick) begin
                    if (r_cnt == HOLD_LAST) begin
                        w_state_nxt = ST_CLOSING;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt = r_cnt + CW'(1);
                    end
                end
            end
            ST_CLOSING: begin
                if (w_reopen) begin
                    w_state_nxt = ST_OPENING;
                    w_cnt_nxt   = '0;
                end else if (bus.tick) begin
                    if (r_cnt == CLOSE_LAST) begin
                        w_state_nxt = ST_CLOSED;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt = r_cnt + CW'(1);
                    end
                end
            end
            default: begin
                w_state_nxt = ST_CLOSED;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // Outputs decoded from the state register.
    always_comb begin
        bus.door_state   = r_state;
        bus.door_closed  = (r_state == ST_CLOSED);
        bus.tick_en      = (r_state != ST_CLOSED);
        bus.closed_pulse = r_closed_pulse;
    end

endmodule

// File: tb/tb_door_timer_fsm.sv
module tb_door_timer_fsm;

    logic clk;
    logic reset;

    door_timer_fsm_if bus ();

    door_timer_fsm #(
        .OPEN_TICKS (3),
        .HOLD_TICKS (5),
        .CLOSE_TICKS(3)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] st;
        logic       pulse;
        int         idx;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   vec   = 0;

    // Driver: inputs applied at the falling edge; expected outputs after
    // the following rising edge are pushed for the monitor.
    task automatic drive(input logic tk, input logic orq, input logic obtn,
                         input logic cbtn, input logic obs, input logic rst,
                         input logic [1:0] es, input logic ep);
        exp_t e;
        @(negedge clk);
        bus.tick      = tk;
        bus.open_req  = orq;
        bus.open_btn  = obtn;
        bus.close_btn = cbtn;
        bus.obstruct  = obs;
        reset         = rst;
        e.st    = es;
        e.pulse = ep;
        e.idx   = vec;
        vec++;
        q.push_back(e);
    endtask

    task automatic idle(input int n, input logic [1:0] es);
        for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 1, es, 0);
    endtask

    // n non-terminal ticks, one every 4 cycles, state unchanged
    task automatic ticks(input int n, input logic [1:0] es);
        for (int i = 0; i < n; i++) begin
            idle(3, es);
            drive(1, 0, 0, 0, 0, 1, es, 0);
        end
    endtask

    // Monitor: compares DUT outputs shortly after each rising edge.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (q.size() > 0) begin
            e = q.pop_front();
            n_cmp++;
            if (bus.door_state !== e.st) begin
                n_bad++;
                $display("FAIL door_state vec %0d: got %0d expected %0d", e.idx, bus.door_state, e.st);
            end
            n_cmp++;
            if (bus.door_closed !== (e.st == 2'd0)) begin
                n_bad++;
                $display("FAIL door_closed vec %0d: got %0b expected %0b", e.idx, bus.door_closed, (e.st == 2'd0));
            end
            n_cmp++;
            if (bus.tick_en !== (e.st != 2'd0)) begin
                n_bad++;
                $display("FAIL tick_en vec %0d: got %0b expected %0b", e.idx, bus.tick_en, (e.st != 2'd0));
            end
            n_cmp++;
            if (bus.closed_pulse !== e.pulse) begin
                n_bad++;
                $display("FAIL closed_pulse vec %0d: got %0b expected %0b", e.idx, bus.closed_pulse, e.pulse);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, queue depth %0d expected 0", q.size());
        $fatal(1, "watchdog");
    end

    initial begin
        reset         = 1'b0;
        bus.tick      = 1'b0;
        bus.open_req  = 1'b0;
        bus.open_btn  = 1'b0;
        bus.close_btn = 1'b0;
        bus.obstruct  = 1'b0;

        // Reset held 3 cycles with open_req high, then released with it low
        for (int i = 0; i < 3; i++) drive(0, 1, 0, 0, 0, 0, 2'd0, 0);
        drive(0, 0, 0, 0, 0, 1, 2'd0, 0);

        // Ticks while CLOSED are ignored
        for (int i = 0; i < 4; i++) drive(1, 0, 0, 0, 0, 1, 2'd0, 0);

        // Undisturbed cycle: 1->2 on 3rd tick, 2->3 on 8th, 3->0 on 11th
        drive(0, 1, 0, 0, 0, 1, 2'd1, 0);
        ticks(2, 2'd1);
        idle(3, 2'd1);
        drive(1, 0, 0, 0, 0, 1, 2'd2, 0);
        ticks(4, 2'd2);
        idle(3, 2'd2);
        drive(1, 0, 0, 0, 0, 1, 2'd3, 0);
        ticks(2, 2'd3);
        idle(3, 2'd3);
        drive(1, 0, 0, 0, 0, 1, 2'd0, 1);
        idle(3, 2'd0);

        // Hold restart: obstruct coincident with the would-be terminal tick
        drive(0, 1, 0, 0, 0, 1, 2'd1, 0);
        ticks(2, 2'd1);
        idle(3, 2'd1);
        drive(1, 0, 0, 0, 0, 1, 2'd2, 0);
        ticks(4, 2'd2);
        idle(3, 2'd2);
        drive(1, 0, 0, 0, 1, 1, 2'd2, 0);
        ticks(4, 2'd2);
        idle(3, 2'd2);
        drive(1, 0, 0, 0, 0, 1, 2'd3, 0);

        // Reopen during closing: obstruct on the terminal tick
        ticks(2, 2'd3);
        idle(3, 2'd3);
        drive(1, 0, 0, 0, 1, 1, 2'd1, 0);

        // OPENING ignores close_btn and obstruct; exits only on its 3rd tick
        for (int t = 0; t < 2; t++) begin
            for (int i = 0; i < 3; i++) drive(0, 0, 0, 1, 1, 1, 2'd1, 0);
            drive(1, 0, 0, 1, 1, 1, 2'd1, 0);
        end
        for (int i = 0; i < 3; i++) drive(0, 0, 0, 1, 1, 1, 2'd1, 0);
        drive(1, 0, 0, 1, 1, 1, 2'd2, 0);

        // Early close at cnt=1
        ticks(1, 2'd2);
        drive(0, 0, 0, 1, 0, 1, 2'd3, 0);
        ticks(2, 2'd3);
        idle(3, 2'd3);
        drive(1, 0, 0, 0, 0, 1, 2'd0, 1);
        idle(2, 2'd0);

        // open_btn opens from CLOSED; open_btn+close_btn at cnt=1 restarts hold
        drive(0, 0, 1, 0, 0, 1, 2'd1, 0);
        ticks(2, 2'd1);
        idle(3, 2'd1);
        drive(1, 0, 0, 0, 0, 1, 2'd2, 0);
        ticks(1, 2'd2);
        drive(0, 0, 1, 1, 0, 1, 2'd2, 0);
        ticks(4, 2'd2);
        idle(3, 2'd2);
        drive(1, 0, 0, 0, 0, 1, 2'd3, 0);

        // open_req during CLOSING reopens, then reset mid-OPEN
        drive(0, 1, 0, 0, 0, 1, 2'd1, 0);
        ticks(2, 2'd1);
        idle(3, 2'd1);
        drive(1, 0, 0, 0, 0, 1, 2'd2, 0);
        idle(2, 2'd2);
        drive(0, 0, 0, 0, 0, 0, 2'd0, 0);
        idle(3, 2'd0);

        @(posedge clk);
        #2;
        n_cmp++;
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL queue_drain: got %0d pending expected 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
